// File: rtl/ram_stream_reader.sv
// Streams a contiguous, wrapping run of RAM words out over valid/ready with a last flag.
// Absorbs the RAM's one-cycle read latency with a two-entry output buffer.
module ram_stream_reader #(
   parameter  int WIDTH_P = 8,
   parameter  int DEPTH_P = 16,
   localparam int AW      = $clog2(DEPTH_P)
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               start_i,
   input  logic [AW-1:0]      base_addr_i,
   input  logic [AW:0]        len_i,
   output logic               rd_en_o,
   output logic [AW-1:0]      rd_addr_o,
   input  logic [WIDTH_P-1:0] rd_data_i,
   output logic [WIDTH_P-1:0] data_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               last_o,
   output logic               busy_o,
   output logic               done_o
);

   // state   | meaning
   // ST_IDLE | waiting for start_i; latches base/len on start
   // ST_READ | issuing reads and draining the output buffer
   // ST_DONE | one-cycle done_o pulse, start_i ignored
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [AW:0]        rem_q, rem_d;
   logic [AW-1:0]      nxt_addr_q, nxt_addr_d;
   logic [AW-1:0]      addr_hold_q, addr_hold_d;
   logic               inf_q, inf_d;
   logic               inf_last_q, inf_last_d;
   logic [1:0]         occ_q, occ_d;
   logic [WIDTH_P-1:0] head_q, head_d;
   logic               head_last_q, head_last_d;
   logic [WIDTH_P-1:0] tail_q, tail_d;
   logic               tail_last_q, tail_last_d;

   logic pop;
   logic rd_en;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         nxt_addr_q  <= '0;
         addr_hold_q <= '0;
         inf_q       <= 1'b0;
         inf_last_q  <= 1'b0;
         occ_q       <= '0;
         head_q      <= '0;
         head_last_q <= 1'b0;
         tail_q      <= '0;
         tail_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         nxt_addr_q  <= nxt_addr_d;
         addr_hold_q <= addr_hold_d;
         inf_q       <= inf_d;
         inf_last_q  <= inf_last_d;
         occ_q       <= occ_d;
         head_q      <= head_d;
         head_last_q <= head_last_d;
         tail_q      <= tail_d;
         tail_last_q <= tail_last_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      nxt_addr_d  = nxt_addr_q;
      addr_hold_d = addr_hold_q;
      occ_d       = occ_q;
      head_d      = head_q;
      head_last_d = head_last_q;
      tail_d      = tail_q;
      tail_last_d = tail_last_q;

      pop = (occ_q != 2'd0) && ready_i;
      // occ + inf never exceeds 2, so a third read is only issued when a pop frees a slot
      rd_en = (state_q == ST_READ) && (rem_q != '0) &&
              (((occ_q + {1'b0, inf_q}) < 2'd2) || pop);

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               rem_d      = len_i;
               nxt_addr_d = base_addr_i;
               occ_d      = '0;
               state_d    = (len_i == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            if (pop && head_last_q) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // remaining-read down-counter; the address wraps naturally at AW bits
      if (rd_en) begin
         rem_d       = rem_q - 1'b1;
         nxt_addr_d  = nxt_addr_q + 1'b1;
         addr_hold_d = nxt_addr_q;
      end
      inf_d      = rd_en;
      inf_last_d = rd_en && (rem_q == (AW+1)'(1));

      case ({inf_q, pop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               head_d      = rd_data_i;
               head_last_d = inf_last_q;
            end else begin
               tail_d      = rd_data_i;
               tail_last_d = inf_last_q;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            if (occ_q == 2'd2) begin
               head_d      = tail_q;
               head_last_d = tail_last_q;
            end
            occ_d = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               head_d      = rd_data_i;
               head_last_d = inf_last_q;
            end else begin
               head_d      = tail_q;
               head_last_d = tail_last_q;
               tail_d      = rd_data_i;
               tail_last_d = inf_last_q;
            end
         end
         default: ;
      endcase
   end

   assign rd_en_o   = rd_en;
   assign rd_addr_o = rd_en ? nxt_addr_q : addr_hold_q;
   assign data_o    = head_q;
   assign valid_o   = (occ_q != 2'd0);
   assign last_o    = valid_o && head_last_q;
   assign busy_o    = (state_q != ST_IDLE);
   assign done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized and directed bench for ram_stream_reader with a queue-based reference model.
module tb_ram_stream_reader;
   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             start = 1'b0;
   logic [AW-1:0]    base = '0;
   logic [AW:0]      len = '0;
   logic             ready = 1'b0;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data = '0;
   logic [WIDTH-1:0] data;
   logic             valid, last, busy, done;

   logic [WIDTH-1:0] mem [DEPTH];

   ram_stream_reader #(.WIDTH_P(WIDTH), .DEPTH_P(DEPTH)) dut (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .base_addr_i(base), .len_i(len),
      .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
      .data_o(data), .valid_o(valid), .ready_i(ready), .last_o(last),
      .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk_eq(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // reference model: what the stream must carry, derived from the burst request and RAM contents
   int ph = 0;  // 0 idle, 1 bursting, 2 done pulse
   int m_base, m_len, n_iss, n_acc;
   bit inf_m = 0;
   int expq[$];
   int logq[$];
   int addrq[$];
   bit prev_stall = 0;
   int prev_data, prev_last;
   int start_cyc, first_valid_cyc = -1, last_beat_cyc, done_cyc;
   int done_cnt = 0, valid_cnt = 0;

   always @(negedge clk) begin : monitor
      int occ_m;
      bit pop_m, accept_last;
      int exp_rd;
      if (!rstn) begin
         chk_eq("rst_rd_en", int'(rd_en), 0);
         chk_eq("rst_rd_addr", int'(rd_addr), 0);
         chk_eq("rst_valid", int'(valid), 0);
         chk_eq("rst_busy", int'(busy), 0);
         chk_eq("rst_done", int'(done), 0);
         ph = 0; n_iss = 0; n_acc = 0; inf_m = 0; prev_stall = 0;
         expq.delete();
      end else begin
         occ_m = n_iss - n_acc - int'(inf_m);
         chk_eq("busy", int'(busy), int'(ph != 0));
         chk_eq("done", int'(done), int'(ph == 2));
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (valid) valid_cnt++;
         if (prev_stall) begin
            chk_eq("hold_valid", int'(valid), 1);
            chk_eq("hold_data", int'(data), prev_data);
            chk_eq("hold_last", int'(last), prev_last);
         end
         pop_m = 0;
         accept_last = 0;
         if (ph == 1) begin
            chk_eq("valid", int'(valid), int'(occ_m != 0));
            pop_m = (occ_m != 0) && ready;
            exp_rd = int'((n_iss < m_len) && (((n_iss - n_acc) < 2) || pop_m));
            chk_eq("rd_en", int'(rd_en), exp_rd);
            if (rd_en) begin
               chk_eq("rd_addr", int'(rd_addr), (m_base + n_iss) % DEPTH);
               addrq.push_back(int'(rd_addr));
            end
            if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (valid && ready) begin
               if (expq.size() == 0) begin
                  chk_eq("extra_word_count", n_acc + 1, m_len);
               end else begin
                  chk_eq("data", int'(data), expq[0]);
                  chk_eq("last", int'(last), int'(n_acc == m_len - 1));
                  void'(expq.pop_front());
               end
               logq.push_back(int'(data));
               accept_last = (n_acc == m_len - 1);
               if (accept_last) last_beat_cyc = cyc;
               n_acc++;
            end
         end else begin
            chk_eq("idle_valid", int'(valid), 0);
            chk_eq("idle_rd_en", int'(rd_en), 0);
         end
         prev_stall = valid && !ready;
         prev_data  = int'(data);
         prev_last  = int'(last);
         inf_m = (ph == 1) && rd_en;
         if (inf_m) n_iss++;
         case (ph)
            2: ph = 0;
            1: if (accept_last) begin
                  chk_eq("issued_all", n_iss, m_len);
                  ph = 2;
               end
            default: if (start) begin
                  m_base = int'(base);
                  m_len  = int'(len);
                  n_iss = 0; n_acc = 0;
                  expq.delete();
                  for (int i = 0; i < m_len; i++) expq.push_back(int'(mem[(m_base + i) % DEPTH]));
                  start_cyc = cyc + 1;
                  ph = (m_len == 0) ? 2 : 1;
               end
         endcase
      end
   end

   function automatic bit pick_ready(input int mode);
      return (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 65);
   endfunction

   task automatic clear_logs();
      logq.delete();
      addrq.delete();
      first_valid_cyc = -1;
   endtask

   task automatic run_burst(input int b, input int l, input int mode, input int budget);
      int d0;
      int n;
      d0 = done_cnt;
      @(posedge clk); #1;
      base = AW'(b); len = (AW+1)'(l); start = 1'b1; ready = pick_ready(mode);
      @(posedge clk); #1;
      start = 1'b0; ready = pick_ready(mode);
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clk); #1;
         ready = pick_ready(mode);
         n++;
      end
      if (done_cnt == d0) chk_eq("burst_timeout", n, -1);
   endtask

   task automatic wait_accepts(input int k, input int budget);
      int n;
      n = 0;
      while (n_acc < k && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (n_acc < k) chk_eq("accept_timeout", n_acc, k);
   endtask

   task automatic wait_done_fixed(input int budget);
      int d0;
      int n;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (done_cnt == d0) chk_eq("done_timeout", n, -1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, v0, pat[10];
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("reset_data", int'(data), 0);
      chk_eq("reset_last", int'(last), 0);
      rstn = 1'b1;
      repeat (2) @(posedge clk);

      // full-rate burst
      mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
      clear_logs();
      run_burst(0, 4, 0, 40);
      chk_eq("t1_busy_after", int'(busy), 0);
      chk_eq("t1_first_valid_lat", first_valid_cyc - start_cyc, 2);
      chk_eq("t1_last_beat_lat", last_beat_cyc - start_cyc, 5);
      chk_eq("t1_done_lat", done_cyc - start_cyc, 6);
      chk_eq("t1_count", logq.size(), 4);
      if (logq.size() == 4) begin
         chk_eq("t1_w0", logq[0], 10); chk_eq("t1_w1", logq[1], 20);
         chk_eq("t1_w2", logq[2], 30); chk_eq("t1_w3", logq[3], 40);
      end

      // wrap-around
      mem[14] = 8'hAA; mem[15] = 8'hBB; mem[0] = 8'hCC; mem[1] = 8'hDD;
      clear_logs();
      run_burst(14, 4, 0, 40);
      chk_eq("t2_count", logq.size(), 4);
      if (logq.size() == 4 && addrq.size() == 4) begin
         chk_eq("t2_a0", addrq[0], 14); chk_eq("t2_a1", addrq[1], 15);
         chk_eq("t2_a2", addrq[2], 0);  chk_eq("t2_a3", addrq[3], 1);
         chk_eq("t2_w0", logq[0], 'hAA); chk_eq("t2_w3", logq[3], 'hDD);
      end

      // backpressure
      for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(8'h30 + i);
      pat = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0};
      clear_logs();
      @(posedge clk); #1;
      base = 4'd3; len = 5'd8; start = 1'b1; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_accepts(1, 20);
      foreach (pat[i]) begin
         ready = pat[i][0];
         @(posedge clk); #1;
      end
      ready = 1'b1;
      wait_done_fixed(40);
      chk_eq("t3_count", logq.size(), 8);
      chk_eq("t3_issues", addrq.size(), 8);
      if (logq.size() == 8) begin
         chk_eq("t3_w0", logq[0], 'h33); chk_eq("t3_w7", logq[7], 'h3A);
      end

      // zero length, start held into the done cycle
      clear_logs();
      d0 = done_cnt; v0 = valid_cnt;
      @(posedge clk); #1;
      base = 4'd7; len = '0; start = 1'b1;
      repeat (2) @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk_eq("t4_done_pulses", done_cnt - d0, 1);
      chk_eq("t4_valid_cycles", valid_cnt - v0, 0);
      chk_eq("t4_reads", addrq.size(), 0);

      // start while busy is ignored
      for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(8'h50 + i);
      clear_logs();
      @(posedge clk); #1;
      base = 4'd2; len = 5'd8; start = 1'b1; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 base = 4'd9; len = 5'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done_fixed(40);
      chk_eq("t5_count", logq.size(), 8);
      if (logq.size() == 8) begin
         chk_eq("t5_w0", logq[0], 'h52); chk_eq("t5_w7", logq[7], 'h59);
      end

      // reset mid-stream
      clear_logs();
      @(posedge clk); #1;
      base = 4'd0; len = 5'd8; start = 1'b1; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_accepts(3, 20);
      #2 rstn = 1'b0;
      #1;
      chk_eq("t6_rd_en", int'(rd_en), 0);
      chk_eq("t6_rd_addr", int'(rd_addr), 0);
      chk_eq("t6_data", int'(data), 0);
      chk_eq("t6_valid", int'(valid), 0);
      chk_eq("t6_last", int'(last), 0);
      chk_eq("t6_busy", int'(busy), 0);
      chk_eq("t6_done", int'(done), 0);
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_eq("t6_no_done", done_cnt - d0, 0);
      clear_logs();
      run_burst(0, 2, 0, 30);
      chk_eq("t6_count", logq.size(), 2);
      if (logq.size() == 2) begin
         chk_eq("t6_w0", logq[0], 'h50); chk_eq("t6_w1", logq[1], 'h51);
      end

      // full-depth burst with random backpressure
      clear_logs();
      run_burst(5, DEPTH, 1, 200);
      chk_eq("t7_issues", addrq.size(), DEPTH);
      if (addrq.size() == DEPTH) begin
         chk_eq("t7_a10", addrq[10], 15); chk_eq("t7_a11", addrq[11], 0);
      end

      // random bursts
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
         clear_logs();
         run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)), 1, 300);
         chk_eq("rand_count", logq.size(), m_len);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
